csi2_cam_init_ctrl: RTL

//  Sequencer between the CSI-2 RX CSR block and the camera/D-PHY front end.
//  - On a camera-reset strobe it resets the sensor and waits for sensor boot.
//  - Loads lane IDELAY taps, enables the PHY, waits for byte-clock lock, then runs.
//  - Re-applies lane delays on DELAY_ACT and clears statistics counters.
//  - Exposes its state and a lock-timeout fault back to the status registers.

---
 rtl/csi2_cam_init_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/csi2_cam_init_ctrl.sv
// rtl/csi2_cam_init_ctrl.sv - camera reset / lane delay / D-PHY bring-up sequencer
module csi2_cam_init_ctrl #(
    parameter int CAM_RST_CYCLES      = 1000,
    parameter int CAM_BOOT_CYCLES     = 20000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int DELAY_W             = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cam_rst_stb_i,
    input  logic               phy_enable_i,
    input  logic               delay_act_i,
    input  logic               clear_stat_i,
    input  logic [DELAY_W-1:0] lane0_delay_i,
    input  logic [DELAY_W-1:0] lane1_delay_i,
    input  logic               idelay_rdy_i,
    input  logic               byte_clk_locked_i,
    output logic               cam_rst_n_o,
    output logic               phy_en_o,
    output logic [DELAY_W-1:0] lane0_delay_o,
    output logic [DELAY_W-1:0] lane1_delay_o,
    output logic               delay_ld_o,
    output logic               stat_clear_o,
    output logic [3:0]         state_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int MAX_A  = (CAM_RST_CYCLES > CAM_BOOT_CYCLES) ? CAM_RST_CYCLES : CAM_BOOT_CYCLES;
    localparam int MAX_C  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(CAM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LD = CNT_W'(CAM_BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CAM_RST   = 4'd1,
        CAM_BOOT  = 4'd2,
        DLY_LOAD  = 4'd3,
        DLY_WAIT  = 4'd4,
        PHY_ON    = 4'd5,
        WAIT_LOCK = 4'd6,
        RUN       = 4'd7,
        FAULT     = 4'd8
    } state_t;

    state_t           state, nxt, ret_state, ret_nxt;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_comb begin
        nxt     = state;
        ret_nxt = ret_state;
        if (cam_rst_stb_i) begin
            nxt = CAM_RST;
        end else begin
            case (state)
                IDLE: if (delay_act_i) begin
                    nxt     = DLY_LOAD;
                    ret_nxt = IDLE;
                end
                CAM_RST:  if (cnt_zero) nxt = CAM_BOOT;
                CAM_BOOT: if (cnt_zero) begin
                    nxt     = DLY_LOAD;
                    ret_nxt = PHY_ON;
                end
                DLY_LOAD: nxt = DLY_WAIT;
                DLY_WAIT: begin
                    if (idelay_rdy_i)  nxt = ret_state;
                    else if (cnt_zero) nxt = FAULT;
                end
                PHY_ON: if (phy_enable_i) nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (byte_clk_locked_i) nxt = RUN;
                    else if (cnt_zero)     nxt = FAULT;
                end
                // phy_enable drop beats lock loss, which beats delay_act
                RUN: begin
                    if (!phy_enable_i)           nxt = IDLE;
                    else if (!byte_clk_locked_i) nxt = WAIT_LOCK;
                    else if (delay_act_i) begin
                        nxt     = DLY_LOAD;
                        ret_nxt = RUN;
                    end
                end
                FAULT:   nxt = FAULT;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_load = '0;
        case (nxt)
            CAM_RST:             cnt_load = RST_LD;
            CAM_BOOT:            cnt_load = BOOT_LD;
            DLY_WAIT, WAIT_LOCK: cnt_load = TO_LD;
            default:             cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            cnt           <= '0;
            cam_rst_n_o   <= 1'b1;
            phy_en_o      <= 1'b0;
            lane0_delay_o <= '0;
            lane1_delay_o <= '0;
            delay_ld_o    <= 1'b0;
            stat_clear_o  <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state     <= nxt;
            ret_state <= ret_nxt;
            if (nxt != state || cam_rst_stb_i) cnt <= cnt_load;
            else if (!cnt_zero)                cnt <= cnt - 1'b1;
            cam_rst_n_o  <= (nxt != CAM_RST);
            // PHY stays enabled while a delay reload runs out of RUN
            phy_en_o     <= (nxt == WAIT_LOCK) || (nxt == RUN) ||
                            (((nxt == DLY_LOAD) || (nxt == DLY_WAIT)) && (ret_nxt == RUN));
            delay_ld_o   <= (nxt == DLY_LOAD);
            if (nxt == DLY_LOAD) begin
                lane0_delay_o <= lane0_delay_i;
                lane1_delay_o <= lane1_delay_i;
            end
            stat_clear_o <= clear_stat_i || ((nxt == RUN) && (state != RUN));
            timeout_o    <= (nxt == FAULT) || (timeout_o && !cam_rst_stb_i);
        end
    end

    assign state_o = state;
    assign busy_o  = !((state == IDLE) || (state == RUN) || (state == FAULT));

endmodule
